// File: rtl/arb_pkg.sv
// Shared constants and helpers for the arb_v1 request arbiter.
// Latency: n/a (compile-time constants and pure functions only).
// Backpressure: n/a.
package arb_pkg;

  localparam int ARB_MAX_PORTS = 32;

  // Ceiling log2, usable in localparam expressions; never returns less than 1.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  localparam int ARB_IDX_W = clog2(ARB_MAX_PORTS);

  // Index of the set bit in a one-hot vector; an all-zero vector yields 0.
  function automatic logic [ARB_IDX_W-1:0] onehot_to_idx(input logic [ARB_MAX_PORTS-1:0] oh);
    logic [ARB_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < ARB_MAX_PORTS; i++) begin
      if (oh[i]) begin
        idx = idx | ARB_IDX_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_v1_if.sv
// Request/grant bundle between the requesting agents and the arbiter.
// Latency: n/a (wires only); grant is combinational from request.
// Backpressure: none; a grant is valid only in the cycle it is asserted.
interface arb_v1_if #(
  parameter int NUM_PORTS = 8
);

  logic [NUM_PORTS-1:0] req_i;
  logic [NUM_PORTS-1:0] gnt_o;

  modport master (output req_i, input gnt_o);
  modport slave  (input req_i, output gnt_o);

endinterface

// File: rtl/arb_fp_enc.sv
// Fixed-priority encoder: keeps only the lowest-index set bit of the input.
// Latency: 0 cycles, purely combinational.
// Backpressure: none.
module arb_fp_enc #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] gnt
);

  // Two's-complement trick: x & -x isolates the lowest set bit (zero stays zero).
  always_comb begin
    gnt = req & (~req + WIDTH'(1));
  end

endmodule

// File: rtl/arb_v1.sv
// N-way request arbiter, one-hot grant; round-robin when ARB_V1_ROUND_ROBIN_EN
// is defined, lowest-index fixed priority otherwise.
// Latency: grant is combinational from req_i/ptr/rst; ptr updates on the next edge. No backpressure.
module arb_v1
  import arb_pkg::*;
#(
  parameter int NUM_PORTS = 8
) (
  input logic     clk,
  input logic     rst,
  arb_v1_if.slave bus
);

  logic [NUM_PORTS-1:0] gnt_u;
  logic [NUM_PORTS-1:0] gnt;

  // Unmasked encoder: lowest requesting index overall.
  arb_fp_enc #(.WIDTH(NUM_PORTS)) u_enc_unmasked (
    .req (bus.req_i),
    .gnt (gnt_u)
  );

`ifdef ARB_V1_ROUND_ROBIN_EN

  localparam int PTR_W = clog2(NUM_PORTS);

  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     ptr_next;
  logic [NUM_PORTS-1:0] mask;
  logic [NUM_PORTS-1:0] req_m;
  logic [NUM_PORTS-1:0] gnt_m;

  // Keep only requesters at or above the pointer; those win over wrapped-around ones.
  always_comb begin
    mask = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      mask[i] = (i >= int'(ptr));
    end
    req_m = bus.req_i & mask;
  end

  arb_fp_enc #(.WIDTH(NUM_PORTS)) u_enc_masked (
    .req (req_m),
    .gnt (gnt_m)
  );

  // Masked result if any requester sits at/after ptr, otherwise wrap to the unmasked one.
  always_comb begin
    gnt = '0;
    if (!rst) begin
      gnt = (|gnt_m) ? gnt_m : gnt_u;
    end
  end

  // Next pointer is one past the granted port, wrapping at NUM_PORTS-1.
  always_comb begin
    int g;
    g = int'(onehot_to_idx(ARB_MAX_PORTS'(gnt)));
    ptr_next = (g == NUM_PORTS - 1) ? '0 : PTR_W'(g + 1);
  end

  // Pointer register: cleared by reset, advanced only when a grant is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (|gnt) begin
      ptr <= ptr_next;
    end
  end

`else

  // Fixed priority needs no state; clk is kept only for a uniform port list.
  wire unused_clk = clk;

  // Lowest index wins; reset still blanks the grant.
  always_comb begin
    gnt = '0;
    if (!rst) begin
      gnt = gnt_u;
    end
  end

`endif

  assign bus.gnt_o = gnt;

endmodule

// File: tb/tb_arb_v1.sv
// Scoreboard bench for arb_v1: directed vectors plus randomized traffic with reset pulses.
// Expected grants are queued at stimulus time and popped by an independent monitor.
// Covers both the round-robin and fixed-priority builds via ARB_V1_ROUND_ROBIN_EN.
module tb_arb_v1;

  localparam int N = 8;
`ifdef ARB_V1_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arb_v1_if #(.NUM_PORTS(N)) bus ();

  arb_v1 #(.NUM_PORTS(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [N-1:0] exp_q[$];
  int           pass_cnt = 0;
  int           total_cnt = 0;
  int           model_ptr = 0;
  logic [N-1:0] last_g = '0;
  int           wait_cnt[N];

  task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s at %0t: got %h, required %h", name, $time, act, req);
  endtask

  // Reference: scan ports in priority order starting at the pointer, first requester wins.
  function automatic logic [N-1:0] model_gnt(input logic [N-1:0] req, input int p, output int gi);
    logic [N-1:0] r;
    r  = '0;
    gi = -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (p + k) % N;
      if (gi < 0 && req[idx]) begin
        gi     = idx;
        r[idx] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [N-1:0] pick(input logic [N-1:0] rr_val, input logic [N-1:0] fp_val);
    return RR ? rr_val : fp_val;
  endfunction

  // Apply one cycle of stimulus; queue either a fixed expectation or the model's.
  task automatic drive(input bit r, input logic [N-1:0] req, input bit use_c, input logic [N-1:0] c);
    logic [N-1:0] g;
    int gi;
    @(posedge clk);
    #1;
    rst       = r;
    bus.req_i = req;
    g = model_gnt(req, model_ptr, gi);
    if (r) g = '0;
    exp_q.push_back(use_c ? c : g);
    last_g = g;
    if (r) model_ptr = 0;
    else if (RR && gi >= 0) model_ptr = (gi + 1) % N;
  endtask

  // Monitor: compare against the scoreboard and the invariants on every falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [N-1:0] e;
      e = exp_q.pop_front();
      check("gnt", bus.gnt_o == e, 32'(bus.gnt_o), 32'(e));
      check("onehot0", $onehot0(bus.gnt_o), 32'(bus.gnt_o), 32'(bus.req_i));
      check("subset", (bus.gnt_o & ~bus.req_i) == '0, 32'(bus.gnt_o), 32'(bus.req_i));
      if (RR) begin
        for (int i = 0; i < N; i++) begin
          if (rst || !bus.req_i[i] || bus.gnt_o[i]) begin
            wait_cnt[i] = 0;
          end else begin
            wait_cnt[i] = wait_cnt[i] + 1;
            check("starve", wait_cnt[i] < N, 32'(wait_cnt[i]), 32'(N - 1));
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] e_single[4];
    logic [N-1:0] rq;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    bus.req_i = 8'hFF;

    // Reset and release
    drive(1'b1, 8'hFF, 1'b1, 8'h00);
    drive(1'b0, 8'h00, 1'b1, 8'h00);

    // Sparse requesters held
    e_single = '{8'h10, 8'h20, 8'h80, 8'h10};
    for (int k = 0; k < 4; k++) drive(1'b0, 8'hB0, 1'b1, pick(e_single[k], 8'h10));

    // Full load from ptr = 0
    drive(1'b1, 8'h00, 1'b1, 8'h00);
    for (int k = 0; k < 10; k++) drive(1'b0, 8'hFF, 1'b1, pick(N'(1 << (k % N)), 8'h01));

    // Wrap from port 7 to port 0
    drive(1'b0, 8'h80, 1'b1, 8'h80);
    drive(1'b0, 8'h81, 1'b1, 8'h01);
    drive(1'b0, 8'h81, 1'b1, pick(8'h80, 8'h01));

    // Idle hold keeps the pointer
    drive(1'b0, 8'h04, 1'b1, 8'h04);
    for (int k = 0; k < 3; k++) drive(1'b0, 8'h00, 1'b1, 8'h00);
    drive(1'b0, 8'h0C, 1'b1, pick(8'h08, 8'h04));

    // Random traffic: requesters mostly hold until granted, occasional bursts and resets
    rq = '0;
    for (int k = 0; k < 10000; k++) begin
      bit r;
      r = ($urandom_range(63) == 0);
      if ($urandom_range(7) == 0) rq = N'($urandom());
      else rq = (rq & ~last_g) | N'($urandom() & $urandom() & $urandom());
      drive(r, rq, 1'b0, '0);
    end

    @(negedge clk);
    #1;
    check("drain", exp_q.size() == 0, 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
